// File: rtl/calc_pkg.sv
// Shared definitions for the RPN stack calculator: key token codes, FSM
// state encodings and the operand width.
package calc_pkg;

   localparam int WIDTH = 16;

   localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
   localparam logic [3:0] KEY_ADD       = 4'ha;
   localparam logic [3:0] KEY_SUB       = 4'hb;
   localparam logic [3:0] KEY_MUL       = 4'hc;
   localparam logic [3:0] KEY_DIV       = 4'hd;
   localparam logic [3:0] KEY_ENT       = 4'he;
   localparam logic [3:0] KEY_CLR       = 4'hf;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DIV  = 2'd2
   } state_e;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. done_o pulses in the
// final iteration cycle with the finished quotient on quotient_o.
module serial_divider
   import calc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o
);

   localparam int CW = $clog2(WIDTH);

   logic             busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH+1:0] rem_shift, diff;
   logic             last;

   always_comb begin
      rem_shift = {rem_q, quo_q[WIDTH-1]};
      diff      = rem_shift - {2'b00, div_q};
      last      = busy_q && (cnt_q == CW'(WIDTH - 1));
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      div_d     = div_q;
      if (busy_q) begin
         // A negative trial difference means the divisor did not fit: restore.
         rem_d = diff[WIDTH+1] ? rem_shift[WIDTH:0] : diff[WIDTH:0];
         quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH+1]};
         cnt_d = cnt_q + 1'b1;
         if (last) busy_d = 1'b0;
      end else if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         rem_d  = '0;
         quo_d  = dividend_i;
         div_d  = divisor_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         div_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         div_q  <= div_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = last;
   assign quotient_o = quo_d;

endmodule

// File: rtl/rpn_stack_calc.sv
// RPN stack calculator front end: assembles decimal operands from key tokens,
// keeps an unsigned operand stack and drives the value shown on the display.
module rpn_stack_calc #(
   parameter int DEPTH = 8,
   parameter int WIDTH = calc_pkg::WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   key_valid,
   input  logic [3:0]             key_code,
   output logic                   key_ready,
   output logic [WIDTH-1:0]       numbers,
   output logic [$clog2(DEPTH):0] depth,
   output logic                   error
);
   import calc_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;

   typedef logic [WIDTH-1:0] word_t;

   state_e        state_q, state_d;
   logic [3:0]    op_q, op_d;
   word_t         entry_q, entry_d;
   logic          active_q, active_d;
   logic [DW-1:0] depth_q, depth_d;
   logic          error_q, error_d;
   word_t         numbers_q, numbers_d;
   word_t         stack_q [DEPTH];
   word_t         stack_d [DEPTH];

   logic [AW-1:0] push_idx, top_idx, next_idx;
   word_t         a_val, b_val, alu_res;
   logic          full, accept;
   logic [19:0]   digit_val;
   logic          div_start, div_busy, div_done;
   word_t         div_quot;

   assign key_ready = (state_q == ST_IDLE);
   assign accept    = key_valid && key_ready;
   assign full      = (depth_q == DW'(DEPTH));
   assign push_idx  = AW'(depth_q);
   assign top_idx   = AW'(depth_q - DW'(1));
   assign next_idx  = AW'(depth_q - DW'(2));
   assign b_val     = stack_q[top_idx];
   assign a_val     = stack_q[next_idx];
   assign digit_val = 20'(entry_q) * 20'd10 + 20'(key_code);

   always_comb begin
      case (op_q)
         KEY_ADD: alu_res = a_val + b_val;
         KEY_SUB: alu_res = a_val - b_val;
         KEY_MUL: alu_res = a_val * b_val;
         default: alu_res = '0;
      endcase
   end

   // NOTE: combinational next-state logic assigns every *_d a default first and
   // uses blocking '='; only the clocked blocks below use '<='.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      entry_d   = entry_q;
      active_d  = active_q;
      depth_d   = depth_q;
      error_d   = error_q;
      stack_d   = stack_q;
      div_start = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (key_code <= KEY_DIGIT_MAX) begin
                  if (!active_q) begin
                     entry_d  = WIDTH'(key_code);
                     active_d = 1'b1;
                  end else if (digit_val[19:WIDTH] != '0) begin
                     error_d = 1'b1;
                  end else begin
                     entry_d = digit_val[WIDTH-1:0];
                  end
               end else if (key_code == KEY_CLR) begin
                  depth_d  = '0;
                  entry_d  = '0;
                  active_d = 1'b0;
                  error_d  = 1'b0;
               end else begin
                  // Enter and every operator first push a pending entry.
                  if (active_q) begin
                     if (full) begin
                        error_d = 1'b1;
                     end else begin
                        stack_d[push_idx] = entry_q;
                        depth_d           = depth_q + DW'(1);
                     end
                     active_d = 1'b0;
                  end
                  if (key_code != KEY_ENT && !(active_q && full)) begin
                     op_d    = key_code;
                     state_d = ST_EXEC;
                  end
               end
            end
         end

         ST_EXEC: begin
            state_d = ST_IDLE;
            if (depth_q < DW'(2)) begin
               error_d = 1'b1;
            end else if (op_q == KEY_DIV) begin
               if (b_val == '0) begin
                  error_d = 1'b1;
               end else begin
                  div_start = 1'b1;
                  state_d   = ST_DIV;
               end
            end else begin
               stack_d[next_idx] = alu_res;
               depth_d           = depth_q - DW'(1);
            end
         end

         ST_DIV: begin
            if (div_done) begin
               stack_d[next_idx] = div_quot;
               depth_d           = depth_q - DW'(1);
               state_d           = ST_IDLE;
            end else if (!div_busy) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      numbers_d = active_d ? entry_d
                : (depth_d != '0) ? stack_d[AW'(depth_d - DW'(1))] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         op_q      <= KEY_ADD;
         entry_q   <= '0;
         active_q  <= 1'b0;
         depth_q   <= '0;
         error_q   <= 1'b0;
         numbers_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         entry_q   <= entry_d;
         active_q  <= active_d;
         depth_q   <= depth_d;
         error_q   <= error_d;
         numbers_q <= numbers_d;
      end
   end

   // NOTE: stack contents need no reset; depth_q alone decides which slots are live.
   always_ff @(posedge clk) begin
      stack_q <= stack_d;
   end

   serial_divider u_div (
      .clk        (clk),
      .rst        (rst),
      .start_i    (div_start),
      .dividend_i (a_val),
      .divisor_i  (b_val),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quotient_o (div_quot)
   );

   assign numbers = numbers_q;
   assign depth   = depth_q;
   assign error   = error_q;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Directed bench for rpn_stack_calc: hand-computed vectors for entry, stack
// arithmetic, divider latency, error cases and reset.
module tb_rpn_stack_calc;
   import calc_pkg::*;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'h0;
   logic        key_ready;
   logic [15:0] numbers;
   logic [3:0]  depth;
   logic        error;

   int vectors = 0;
   int miscompares = 0;

   rpn_stack_calc #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ready (key_ready),
      .numbers   (numbers),
      .depth     (depth),
      .error     (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input int n, input int d, input int e);
      check({tag, "_numbers"}, 32'(numbers), n);
      check({tag, "_depth"},   32'(depth),   d);
      check({tag, "_error"},   32'(error),   e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers a token and returns #1 after the edge that accepted it.
   task automatic press(input logic [3:0] code);
      int n = 0;
      key_valid = 1'b1;
      key_code  = code;
      while (key_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("ready_wait", 32'(key_ready), 32'd1);
      tick();
      key_valid = 1'b0;
   endtask

   initial begin
      int n_wait;

      // Reset, with a token offered that must be ignored.
      key_valid = 1'b1;
      key_code  = 4'h5;
      repeat (3) tick();
      check("reset_ready", 32'(key_ready), 32'd1);
      check_out("reset", 0, 0, 0);
      key_valid = 1'b0;
      rst = 1'b0;
      tick();
      check_out("post_reset", 0, 0, 0);

      // 1,2,3,e
      press(4'h1); check("digit1", 32'(numbers), 32'd1);
      press(4'h2); check("digit12", 32'(numbers), 32'd12);
      press(4'h3); check("digit123", 32'(numbers), 32'd123);
      press(KEY_ENT);
      check_out("enter123", 123, 1, 0);
      check("enter_ready", 32'(key_ready), 32'd1);
      press(KEY_CLR);
      check_out("clr1", 0, 0, 0);

      // 7,e,5,c -> 35 at t+2
      press(4'h7); press(KEY_ENT); press(4'h5); press(KEY_MUL);
      check("mul_exec_busy", 32'(key_ready), 32'd0);
      tick();
      check_out("mul35", 35, 1, 0);
      check("mul_ready", 32'(key_ready), 32'd1);
      press(KEY_CLR);

      // 1,0,0,e,7,d -> 14 at t+18; token held during DIV accepted only then
      press(4'h1); press(4'h0); press(4'h0); press(KEY_ENT); press(4'h7); press(KEY_DIV);
      key_valid = 1'b1;
      key_code  = 4'h9;
      n_wait = 0;
      while (key_ready !== 1'b1 && n_wait < 40) begin
         tick();
         n_wait++;
      end
      check("div_latency", 32'(n_wait), 32'd17);
      check_out("div14", 14, 1, 0);
      tick();
      key_valid = 1'b0;
      check_out("held_digit", 9, 1, 0);
      press(KEY_CLR);

      // 5,e,0,d -> divide by zero
      press(4'h5); press(KEY_ENT); press(4'h0); press(KEY_DIV);
      tick();
      check_out("divzero", 0, 2, 1);
      check("divzero_ready", 32'(key_ready), 32'd1);
      press(KEY_CLR);
      check_out("clr_error", 0, 0, 0);

      // 65535 boundary, then wrap on add
      press(4'h6); press(4'h5); press(4'h5); press(4'h3); press(4'h5);
      check_out("max_entry", 65535, 0, 0);
      press(4'h6);
      check_out("overflow_digit", 65535, 0, 1);
      press(KEY_ENT);
      check_out("push_max", 65535, 1, 1);
      press(4'h1);
      press(KEY_ADD);
      tick();
      check_out("add_wrap", 0, 1, 1);
      press(KEY_CLR);

      // 3,e,5,b -> 65534
      press(4'h3); press(KEY_ENT); press(4'h5); press(KEY_SUB);
      tick();
      check_out("sub_wrap", 65534, 1, 0);
      press(KEY_CLR);

      // 300*300 = 90000 -> low 16 bits 24464
      press(4'h3); press(4'h0); press(4'h0); press(KEY_ENT);
      press(4'h3); press(4'h0); press(4'h0); press(KEY_MUL);
      tick();
      check_out("mul_wrap", 24464, 1, 0);
      press(KEY_CLR);

      // Fill the stack, then overflow by enter and by operator
      for (int i = 1; i <= DEPTH; i++) begin
         press(4'(i));
         press(KEY_ENT);
      end
      check_out("full", DEPTH, DEPTH, 0);
      press(4'h9); press(KEY_ENT);
      check_out("push_full", DEPTH, DEPTH, 1);
      press(4'h9); press(KEY_ADD);
      check("op_full_ready", 32'(key_ready), 32'd1);
      check_out("op_full", DEPTH, DEPTH, 1);
      press(KEY_CLR);

      // Underflow: + with a single operand
      press(4'h4); press(KEY_ENT); press(KEY_ADD);
      tick();
      check_out("underflow", 4, 1, 1);
      press(KEY_CLR);

      // Reset pulse in the middle of a division
      press(4'h1); press(4'h0); press(4'h0); press(KEY_ENT); press(4'h7); press(KEY_DIV);
      repeat (5) tick();
      check("mid_div_busy", 32'(key_ready), 32'd0);
      rst = 1'b1;
      #2;
      check("rst_ready", 32'(key_ready), 32'd1);
      check_out("rst_mid_div", 0, 0, 0);
      tick();
      rst = 1'b0;
      tick();
      check_out("after_rst", 0, 0, 0);
      press(4'h2); press(KEY_ENT); press(4'h3); press(KEY_MUL);
      tick();
      check_out("after_rst_mul", 6, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
